// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between three requesters.
// Port 0 (ROM/loader) has fixed priority; ports 1 (CPU) and 2 (aux/video)
// alternate round-robin. The controller edge-detects the level rd/we strobes,
// so every access ends with a low-strobe DONE cycle.
module sdram_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_din,
    input  logic [1:0]        p0_wtbt,
    output logic              p0_ack,
    output logic [15:0]       p0_dout,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_din,
    input  logic [1:0]        p1_wtbt,
    output logic              p1_ack,
    output logic [15:0]       p1_dout,

    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [15:0]       p2_din,
    input  logic [1:0]        p2_wtbt,
    output logic              p2_ack,
    output logic [15:0]       p2_dout,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_wtbt,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,

    output logic              busy,
    output logic              err
);

    localparam int SET_W = (SETTLE  < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int TO_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETTLE_WAIT,
        WAIT_READY,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        gnt;
    logic              gnt_we;
    logic              rr_last;   // 1 = port 2 was the last round-robin winner
    logic [SET_W-1:0]  set_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic              win_valid;
    logic [1:0]        win;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_din;
    logic [1:0]        sel_wtbt;
    logic              sel_we;
    logic              fin;
    logic [15:0]       rdata;

    assign busy = (state != IDLE);

    // Winner selection: port 0 first, then round-robin between ports 1 and 2.
    always_comb begin
        win_valid = 1'b0;
        win       = 2'd0;
        if (p0_req) begin
            win_valid = 1'b1;
            win       = 2'd0;
        end else if (p1_req && p2_req) begin
            win_valid = 1'b1;
            win       = rr_last ? 2'd1 : 2'd2;
        end else if (p1_req) begin
            win_valid = 1'b1;
            win       = 2'd1;
        end else if (p2_req) begin
            win_valid = 1'b1;
            win       = 2'd2;
        end
    end

    // Qualifier mux for the selected winner.
    always_comb begin
        sel_addr = p0_addr;
        sel_din  = p0_din;
        sel_wtbt = p0_wtbt;
        sel_we   = p0_we;
        case (win)
            2'd1: begin
                sel_addr = p1_addr;
                sel_din  = p1_din;
                sel_wtbt = p1_wtbt;
                sel_we   = p1_we;
            end
            2'd2: begin
                sel_addr = p2_addr;
                sel_din  = p2_din;
                sel_wtbt = p2_wtbt;
                sel_we   = p2_we;
            end
            default: ;
        endcase
    end

    // Completion in WAIT_READY: real ready, or timeout with 16'hFFFF read data.
    always_comb begin
        fin   = mem_ready || (to_cnt == TO_W'(TIMEOUT - 1));
        rdata = mem_ready ? mem_dout : 16'hFFFF;
    end

    // Arbitration / access sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= 2'd0;
            gnt_we   <= 1'b0;
            rr_last  <= 1'b1;
            set_cnt  <= '0;
            to_cnt   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wtbt <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p2_ack   <= 1'b0;
            p0_dout  <= '0;
            p1_dout  <= '0;
            p2_dout  <= '0;
            err      <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p2_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_ready && win_valid) begin
                        gnt      <= win;
                        gnt_we   <= sel_we;
                        mem_addr <= sel_addr;
                        mem_din  <= sel_din;
                        mem_wtbt <= sel_wtbt;
                        mem_we   <= sel_we;
                        mem_rd   <= !sel_we;
                        if (win != 2'd0) begin
                            rr_last <= (win == 2'd2);
                        end
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // First strobe cycle; ready from the controller is still stale.
                    set_cnt <= SET_W'(1);
                    to_cnt  <= '0;
                    state   <= (SETTLE <= 1) ? WAIT_READY : SETTLE_WAIT;
                end
                SETTLE_WAIT: begin
                    if (set_cnt >= SET_W'(SETTLE - 1)) begin
                        state <= WAIT_READY;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (fin) begin
                        if (!mem_ready) begin
                            err <= 1'b1;
                        end
                        case (gnt)
                            2'd1: begin
                                p1_ack <= 1'b1;
                                if (!gnt_we) p1_dout <= rdata;
                            end
                            2'd2: begin
                                p2_ack <= 1'b1;
                                if (!gnt_we) p2_dout <= rdata;
                            end
                            default: begin
                                p0_ack <= 1'b1;
                                if (!gnt_we) p0_dout <= rdata;
                            end
                        endcase
                        mem_rd <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Strobe is low here so the next access produces a fresh edge.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed testbench for sdram_arbiter with a small behavioural SDRAM
// controller model (edge-detected strobe, programmable ready latency).
module tb_sdram_arbiter;

    localparam int ADDR_W  = 25;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p2_req = 0, p2_we = 0;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0, p2_addr = '0;
    logic [15:0]       p0_din = '0, p1_din = '0, p2_din = '0;
    logic [1:0]        p0_wtbt = '0, p1_wtbt = '0, p2_wtbt = '0;
    logic              p0_ack, p1_ack, p2_ack;
    logic [15:0]       p0_dout, p1_dout, p2_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic [1:0]        mem_wtbt;
    logic              mem_we, mem_rd;
    logic              mem_ready;
    logic [15:0]       mem_dout;
    logic              busy, err;

    // controller model controls
    int          lat     = 0;
    logic        never   = 1'b0;
    logic        wr_keep = 1'b0;
    logic [15:0] rdval   = 16'h0000;
    logic        m_prev;
    logic [7:0]  m_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int who;

    logic [2:0] acks;
    assign acks = {p2_ack, p1_ack, p0_ack};

    sdram_arbiter #(.ADDR_W(ADDR_W), .SETTLE(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din), .p0_wtbt(p0_wtbt),
        .p0_ack(p0_ack), .p0_dout(p0_dout),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din), .p1_wtbt(p1_wtbt),
        .p1_ack(p1_ack), .p1_dout(p1_dout),
        .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din), .p2_wtbt(p2_wtbt),
        .p2_ack(p2_ack), .p2_dout(p2_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wtbt(mem_wtbt),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_dout(mem_dout),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Controller model: ready drops the cycle after a strobe edge is seen and
    // returns lat+1 cycles later with rdval (unless never is set). With
    // wr_keep, writes leave ready high.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready <= 1'b1;
            m_cnt     <= 8'd0;
            m_prev    <= 1'b0;
            mem_dout  <= 16'h0000;
        end else begin
            m_prev <= mem_rd | mem_we;
            if ((mem_rd | mem_we) && !m_prev && !(mem_we && wr_keep)) begin
                mem_ready <= 1'b0;
                m_cnt     <= 8'(lat);
            end else if (!mem_ready) begin
                if (m_cnt != 8'd0) begin
                    m_cnt <= m_cnt - 8'd1;
                end else if (!never) begin
                    mem_ready <= 1'b1;
                    mem_dout  <= rdval;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance at least one cycle, then until any ack or the bound expires.
    task automatic wait_ack(input string tag, input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (acks == 3'b000 && cycles < bound);
        check(tag, {31'b0, acks != 3'b000}, 32'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_mem_rd",   {31'b0, mem_rd}, 32'd0);
        check("rst_mem_we",   {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_err",      {31'b0, err}, 32'd0);
        check("rst_acks",     {29'b0, acks}, 32'd0);
        check("rst_p1_dout",  {16'b0, p1_dout}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ---------------- p1 read, ready after strobe + 6 cycles ----------------
        lat = 4; rdval = 16'hA55A;
        p1_req = 1; p1_we = 0; p1_addr = 25'h000100;
        @(negedge clk);
        check("t1_rd_rise", {31'b0, mem_rd}, 32'd1);
        check("t1_we_low",  {31'b0, mem_we}, 32'd0);
        check("t1_addr",    32'(mem_addr), 32'h100);
        check("t1_busy",    {31'b0, busy}, 32'd1);
        wait_ack("t1_ack_seen", 50, n);
        n++;
        check("t1_latency", 32'(n), 32'd8);
        check("t1_p1_ack",  {29'b0, acks}, 32'b010);
        check("t1_dout",    {16'b0, p1_dout}, 32'hA55A);
        check("t1_rd_done", {31'b0, mem_rd}, 32'd0);
        p1_req = 0;
        @(negedge clk);
        check("t1_ack_1cyc", {31'b0, p1_ack}, 32'd0);
        check("t1_idle",     {31'b0, busy}, 32'd0);

        // ---------------- p2 write, ready held high ----------------
        wr_keep = 1; lat = 0;
        p2_req = 1; p2_we = 1; p2_din = 16'h1234; p2_wtbt = 2'b01; p2_addr = 25'h000003;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (mem_we) begin
                check("wr_addr", 32'(mem_addr), 32'h3);
                check("wr_din",  {16'b0, mem_din}, 32'h1234);
                check("wr_wtbt", {30'b0, mem_wtbt}, 32'b01);
                check("wr_no_rd", {31'b0, mem_rd}, 32'd0);
            end
        end while (!p2_ack && n < 50);
        check("wr_latency", 32'(n), 32'd4);
        check("wr_ack",     {29'b0, acks}, 32'b100);
        check("wr_we_done", {31'b0, mem_we}, 32'd0);
        check("wr_dout_kept", {16'b0, p2_dout}, 32'h0000);
        p2_req = 0; p2_we = 0; p2_wtbt = 2'b00; wr_keep = 0;
        @(negedge clk);

        // ---------------- p1/p2 round-robin, 4 reads ----------------
        rdval = 16'h0F0F;
        p1_req = 1; p1_addr = 25'h000200;
        p2_req = 1; p2_addr = 25'h000400;
        for (int k = 0; k < 4; k++) begin
            wait_ack("rr_ack_seen", 50, n);
            who = p1_ack ? 1 : (p2_ack ? 2 : 0);
            check("rr_order", 32'(who), (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_strobe_low", {31'b0, mem_rd}, 32'd0);
            if (k == 3) begin
                p1_req = 0; p2_req = 0;
            end
        end
        @(negedge clk);

        // ---------------- p0 priority over waiting p1/p2 ----------------
        p0_req = 1; p0_addr = 25'h000010;
        p1_req = 1; p2_req = 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack("p0_ack_seen", 50, n);
            check("p0_only", {29'b0, acks}, 32'b001);
            if (k == 2) p0_req = 0;
        end
        wait_ack("p1_after_p0_seen", 50, n);
        check("p1_after_p0",     {29'b0, acks}, 32'b010);
        check("p1_after_p0_lat", 32'(n), 32'd5);
        p1_req = 0;
        wait_ack("p2_after_p1_seen", 50, n);
        check("p2_after_p1", {29'b0, acks}, 32'b100);
        p2_req = 0;
        @(negedge clk);

        // ---------------- timeout ----------------
        never = 1;
        p1_req = 1; p1_addr = 25'h000800;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 500) begin
                check("to_err_mid",  {31'b0, err}, 32'd0);
                check("to_busy_mid", {31'b0, busy}, 32'd1);
            end
        end while (!p1_ack && n < 1200);
        check("to_latency", 32'(n), 32'(TIMEOUT + 3));
        check("to_ack",     {29'b0, acks}, 32'b010);
        check("to_err",     {31'b0, err}, 32'd1);
        check("to_dout",    {16'b0, p1_dout}, 32'hFFFF);
        p1_req = 0; never = 0;
        rdval = 16'h5A5A;
        @(negedge clk);
        p2_req = 1; p2_addr = 25'h000020;
        wait_ack("post_to_ack_seen", 50, n);
        check("post_to_ack",  {29'b0, acks}, 32'b100);
        check("post_to_dout", {16'b0, p2_dout}, 32'h5A5A);
        check("post_to_err",  {31'b0, err}, 32'd1);
        check("post_to_p1",   {16'b0, p1_dout}, 32'hFFFF);
        p2_req = 0;
        @(negedge clk);

        // ---------------- reset in WAIT_READY ----------------
        lat = 20; rdval = 16'h1111;
        p1_req = 1; p1_addr = 25'h000040;
        repeat (5) @(negedge clk);
        check("rw_busy_before", {31'b0, busy}, 32'd1);
        check("rw_rd_before",   {31'b0, mem_rd}, 32'd1);
        reset_n = 0;
        #1;
        check("rw_rd_drop",  {31'b0, mem_rd}, 32'd0);
        check("rw_no_ack",   {29'b0, acks}, 32'd0);
        check("rw_busy",     {31'b0, busy}, 32'd0);
        check("rw_err_clr",  {31'b0, err}, 32'd0);
        check("rw_dout_clr", {16'b0, p1_dout}, 32'd0);
        @(negedge clk);
        lat = 0; rdval = 16'h2222;
        reset_n = 1;
        wait_ack("rw_ack_seen", 50, n);
        check("rw_latency", 32'(n), 32'd4);
        check("rw_ack",     {29'b0, acks}, 32'b010);
        check("rw_dout",    {16'b0, p1_dout}, 32'h2222);
        p1_req = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
